// File: rtl/morse_digit_display.sv
// Latches each decoded Morse result on the falling edge of the decoder strobe into
// a four-deep history. It scans that history onto a multiplexed active-low seven-segment display.
module morse_digit_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       CLR,
    input  logic       an_in,
    input  logic [3:0] audio_input_number,
    output logic [6:0] seg,
    output logic [3:0] an_out,
    output logic       new_digit,
    output logic [3:0] digit_count
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);

    logic            an_d;
    logic            capture;
    logic [3:0][3:0] hist;
    logic [3:0]      valid;
    logic [RW-1:0]   rcnt;
    logic [1:0]      sidx;
    logic [3:0]      slot_code;
    logic [6:0]      slot_seg;
    logic [6:0]      seg_next;
    logic [3:0]      an_next;

    // an_d resets low, so a strobe that is already low at reset release is not a capture.
    assign capture = an_d & ~an_in;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            an_d        <= 1'b0;
            hist        <= '0;
            valid       <= '0;
            new_digit   <= 1'b0;
            digit_count <= '0;
        end else begin
            an_d      <= an_in;
            new_digit <= 1'b0;
            if (CLR) begin
                hist        <= '0;
                valid       <= '0;
                digit_count <= '0;
            end else if (capture) begin
                hist      <= {hist[2:0], audio_input_number};
                valid     <= {valid[2:0], 1'b1};
                new_digit <= 1'b1;
                if (digit_count != 4'd15)
                    digit_count <= digit_count + 4'd1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            rcnt <= '0;
            sidx <= '0;
        end else if (rcnt == RCNT_LAST) begin
            rcnt <= '0;
            sidx <= sidx + 2'd1;
        end else begin
            rcnt <= rcnt + RW'(1);
        end
    end

    always_comb begin
        slot_code = hist[sidx];
        slot_seg  = 7'b1111111;
        case (slot_code)
            4'd0:    slot_seg = 7'b1000000;
            4'd1:    slot_seg = 7'b1111001;
            4'd2:    slot_seg = 7'b0100100;
            4'd3:    slot_seg = 7'b0110000;
            4'd4:    slot_seg = 7'b0011001;
            4'd5:    slot_seg = 7'b0010010;
            4'd6:    slot_seg = 7'b0000010;
            4'd7:    slot_seg = 7'b1111000;
            4'd8:    slot_seg = 7'b0000000;
            4'd9:    slot_seg = 7'b0010000;
            4'd10:   slot_seg = 7'b1110111;
            4'd11:   slot_seg = 7'b0111111;
            4'd12:   slot_seg = 7'b1111110;
            default: slot_seg = 7'b1111111;
        endcase
        seg_next = 7'b1111111;
        an_next  = 4'b1111;
        // An empty slot leaves every anode off rather than lighting a blank digit.
        if (valid[sidx]) begin
            seg_next = slot_seg;
            an_next  = ~(4'b0001 << sidx);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            seg    <= 7'b1111111;
            an_out <= 4'b1111;
        end else begin
            seg    <= seg_next;
            an_out <= an_next;
        end
    end

endmodule

// File: tb/tb_morse_digit_display.sv
// Bench for morse_digit_display: a queue-based history model predicts every output each cycle
// for directed and randomized strobe sequences.
module tb_morse_digit_display;

    localparam int DIV = 4;

    logic       CLOCK;
    logic       RESET_N;
    logic       CLR;
    logic       an_in;
    logic [3:0] audio_input_number;
    logic [6:0] seg;
    logic [3:0] an_out;
    logic       new_digit;
    logic [3:0] digit_count;

    morse_digit_display #(.REFRESH_DIV(DIV)) dut (
        .CLOCK              (CLOCK),
        .RESET_N            (RESET_N),
        .CLR                (CLR),
        .an_in              (an_in),
        .audio_input_number (audio_input_number),
        .seg                (seg),
        .an_out             (an_out),
        .new_digit          (new_digit),
        .digit_count        (digit_count)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic [6:0] seg_tbl [16];
    logic [3:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         cnt = 0;
    int         pulses = 0;
    logic       prev_an = 1'b0;
    logic       e_nd = 1'b0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_an", {4'h0, an_out}, 8'h0F);
        chk("rst_nd", {7'h0, new_digit}, 8'h00);
        chk("rst_cnt", {4'h0, digit_count}, 8'h00);
    endtask

    task automatic model_reset();
        exp_q.delete();
        cnt     = 0;
        cyc     = 0;
        prev_an = 1'b0;
        e_nd    = 1'b0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare all outputs.
    task automatic step(input logic a, input logic [3:0] n, input logic c);
        int         s;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        an_in = a;
        audio_input_number = n;
        CLR = c;
        @(posedge CLOCK);
        s = (cyc / DIV) % 4;
        if (s < exp_q.size()) begin
            e_seg = seg_tbl[exp_q[s]];
            e_an  = ~(4'b0001 << s);
        end else begin
            e_seg = 7'h7F;
            e_an  = 4'hF;
        end
        if (c) begin
            exp_q.delete();
            cnt  = 0;
            e_nd = 1'b0;
        end else if (prev_an && !a) begin
            exp_q.push_front(n);
            if (exp_q.size() > 4) void'(exp_q.pop_back());
            if (cnt < 15) cnt++;
            e_nd = 1'b1;
        end else begin
            e_nd = 1'b0;
        end
        prev_an = a;
        cyc++;
        #1;
        if (new_digit === 1'b1) pulses++;
        chk("seg", {1'b0, seg}, {1'b0, e_seg});
        chk("an_out", {4'h0, an_out}, {4'h0, e_an});
        chk("new_digit", {7'h0, new_digit}, {7'h0, e_nd});
        chk("digit_count", {4'h0, digit_count}, 8'(cnt));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    endtask

    task automatic cap(input logic [3:0] n);
        int hi = $urandom_range(1, 3);
        int lo = $urandom_range(1, 3);
        for (int i = 0; i < hi; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        for (int i = 0; i < lo; i++) step(1'b0, n, 1'b0);
    endtask

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b1110111, 7'b0111111,
                    7'b1111110, 7'b1111111, 7'b1111111, 7'b1111111};
        RESET_N = 1'b0;
        CLR = 1'b0;
        an_in = 1'b0;
        audio_input_number = 4'd0;
        repeat (3) @(posedge CLOCK);
        #1;
        chk_reset_outputs();
        model_reset();
        RESET_N = 1'b1;

        // strobe already low at release: never a capture
        for (int i = 0; i < 40; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);

        // single capture of 7, watched over two full scans
        pulses = 0;
        cap(4'd7);
        idle(32);
        chk("single_pulse", 8'(pulses), 8'd1);

        // five captures: history keeps the newest four
        step(1'b1, 4'd0, 1'b1);
        for (int i = 1; i <= 5; i++) cap(4'(i));
        idle(20);

        // bar codes and an unmapped code
        step(1'b1, 4'd0, 1'b1);
        cap(4'd10); cap(4'd11); cap(4'd12); cap(4'd14);
        idle(20);

        // count saturation
        for (int i = 0; i < 17; i++) cap(4'($urandom_range(0, 9)));
        idle(4);

        // clear on the same cycle as a capture edge wins
        step(1'b1, 4'd3, 1'b0);
        pulses = 0;
        step(1'b0, 4'd3, 1'b1);
        idle(20);
        chk("clr_no_pulse", 8'(pulses), 8'd0);

        // long low strobe re-armed by a single high cycle
        pulses = 0;
        for (int i = 0; i < 1000; i++) step(1'b0, 4'd6, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 4'd9, 1'b0);
        chk("rearm_pulses", 8'(pulses), 8'd2);

        // randomized captures with occasional clears
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) step(1'b1, 4'd0, 1'b1);
            cap(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 16));
        end
        idle(20);

        // asynchronous reset while a capture edge is pending
        step(1'b1, 4'd5, 1'b0);
        an_in = 1'b0;
        audio_input_number = 4'd5;
        #2;
        RESET_N = 1'b0;
        #1;
        chk_reset_outputs();
        @(posedge CLOCK);
        #1;
        chk_reset_outputs();
        model_reset();
        RESET_N = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 4'd5, 1'b0);
        chk("lost_capture", 8'(pulses), 8'd0);
        cap(4'd8);
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
